cfgreg_mc: RTL
==============

Name: cfgreg_mc

Overview:
- Multi-core successor to the single-core config register block; an APB slave on the system peripheral bus.
- Holds a per-core boot vector, the DDR offset and NSCRATCH scratch registers.
- Runs one reset-release sequencer per core: a software release request drives core_rstn high only after a programmable-length hold.
- Bus protocol is zero-wait-state APB, with pslverr reported for unmapped or blocked writes.

Parameters:
- NCORE, 2: number of cores; 1..16.
- XLEN, 32: boot vector width; 32 or 64.
- NSCRATCH, 2: number of scratch registers; 1..16.
- RST_DLY, 16: cycles from release request to core_rstn high; 0 allowed.
- DDR_OFFSET_RST, 32'h2000_0000: reset value of ddr_offset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- apb_intf  apb_intf.slave  -  APB: 32-bit paddr/pwdata/prdata, with psel, penable, pwrite, pready and pslverr.
- core_bootvec  out  [NCORE][XLEN]  per-core boot vector.
- ddr_offset  out  32  DDR address offset.
- core_rstn  out  NCORE  per-core reset; 0 = core held in reset.

Behaviour:
- Reset, sampled on posedge clk while rst=1:
  - core_bootvec = 0, ddr_offset = DDR_OFFSET_RST, core_rstn = 0, scratch = 0, request bits = 0.
  - All sequencers go to OFF; prdata = 0, pslverr = 0.
- Write strobe: wr = psel & ~penable & pwrite, i.e. the setup phase. Decode uses paddr[11:0]. The register updates on the clock edge that ends the setup phase.
- pready is tied to 1.
- prdata and pslverr are registered in the setup phase and are therefore valid in the access phase.
- Register map:
  - 0x000 RSTREQ, RW: bits[NCORE-1:0] are release requests; upper bits read 0.
  - 0x004 RSTSTAT, RO: bits[NCORE-1:0] = core_rstn. A write returns pslverr=1.
  - 0x008 DDROFFSET, RW, 32 bits.
  - 0x00C LOCK: defined only under the optional feature; otherwise unmapped.
  - 0x100+8*i BOOTVEC_LO[i], RW: bits 31:0.
  - 0x104+8*i BOOTVEC_HI[i], RW when XLEN=64; when XLEN=32 it reads 0 and writes are ignored without error.
  - 0x200+4*j SCRATCH[j], RW.
  - Unmapped, or index ≥ NCORE/NSCRATCH: reads return 0, writes set pslverr=1 and change nothing. Reads never set pslverr.
- Per-core sequencer, with states OFF, HOLD and ON:
  - OFF: core_rstn=0. If req[i]=1: with RST_DLY=0 go to ON; otherwise load cnt=RST_DLY-1 and go to HOLD.
  - HOLD: core_rstn=0. If req[i]=0, go to OFF. Else if cnt==0, go to ON. Else cnt--.
  - ON: core_rstn=1. If req[i]=0, go to OFF (core_rstn=0 on the next cycle).
  - Timing: a request written in cycle T gives core_rstn=1 first in cycle T+1+RST_DLY.
  - Counter width is max(1, $clog2(RST_DLY+1)); the counter never wraps.
- Boot vector changes while a core is in ON take effect immediately on the output. The core samples it only at its reset release.
- Writing RSTREQ with the same value as it already holds leaves the sequencer states unchanged.
- rst asserted mid-HOLD goes to OFF with cnt cleared.

Optional Feature:
- Macro: CFGREG_MC_LOCK_EN.
- When defined, 0x00C LOCK is a write-1-set, sticky register; bit0 is the only bit, and it clears only on rst.
- While LOCK=1:
  - Writes to DDROFFSET and BOOTVEC_* are blocked with pslverr=1.
  - RSTREQ, SCRATCH and LOCK remain writable.
- Writing 0 to LOCK has no effect and no error.
- When undefined: 0x00C is unmapped, and every register is always writable.

Decomposition:
- Package cfgreg_mc_pkg:
  - Register offset localparams: RSTREQ, RSTSTAT, DDROFFSET, LOCK, BOOTVEC_BASE, SCRATCH_BASE.
  - Sequencer state enum rstseq_state_e {OFF, HOLD, ON}.
- Sub-module cfgreg_rstseq: one instance per core.
  - Parameter: RST_DLY.
  - Ports: clk, rst, req, rstn_o.
  - Generate-instantiated NCORE times.

Test Plan:
- Reset: rst high for 2 cycles. Read 0x008 -> 0x2000_0000; read 0x004 -> 0; read 0x100 -> 0; core_rstn=0; pslverr=0.
- Release, NCORE=2, RST_DLY=16: write 0x000=0x1 at cycle T.
  - core_rstn[0] rises at T+17, core_rstn[1] stays 0.
  - Read 0x004 -> 0x1 afterwards.
- Abort: write 0x000=0x3, then write 0x000=0x0 at T+5, before the hold expires. core_rstn stays 0 throughout. RST_DLY=0 build: core_rstn rises at T+1.
- Boot vectors: write 0x108=0x8000_0000 -> core_bootvec[1]=0x8000_0000 and core_bootvec[0] unchanged. XLEN=64: write 0x10C=0x1 -> core_bootvec[1]=0x1_8000_0000.
- Errors: write 0x300, write 0x004 and write 0x110 (NCORE=2) -> each gives pslverr=1 in the access phase with no state change. Read 0x300 -> 0 with pslverr=0.
- Lock (CFGREG_MC_LOCK_EN): write 0x00C=1, then write 0x008=0x4000_0000 -> pslverr=1 and ddr_offset stays 0x2000_0000. Write 0x200=0xDEAD_BEEF succeeds. rst clears LOCK.

Source files
------------

// File: rtl/cfgreg_mc_pkg.sv
// Shared definitions for the multi-core config register block: register
// offsets, the reset-sequencer state type and a counter-width helper.
package cfgreg_mc_pkg;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned ADDR_W = 12;

  // Register offsets within the 4 KiB window (paddr[11:0])
  localparam logic [ADDR_W-1:0] RSTREQ       = 12'h000;
  localparam logic [ADDR_W-1:0] RSTSTAT      = 12'h004;
  localparam logic [ADDR_W-1:0] DDROFFSET    = 12'h008;
  localparam logic [ADDR_W-1:0] LOCK         = 12'h00C;
  localparam logic [ADDR_W-1:0] BOOTVEC_BASE = 12'h100;
  localparam logic [ADDR_W-1:0] SCRATCH_BASE = 12'h200;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HOLD = 2'd1,
    ON   = 2'd2
  } rstseq_state_e;

  // Hold counter width: max(1, clog2(dly+1))
  function automatic int unsigned cnt_width(input int unsigned dly);
    return (dly == 0) ? 1 : $clog2(dly + 1);
  endfunction

endpackage

// File: rtl/apb_intf.sv
// APB bus bundle: 32-bit address/data, psel/penable/pwrite handshake,
// pready/pslverr completion.
//   slave  : receives paddr/pwdata/psel/penable/pwrite, drives prdata/pready/pslverr
//   master : the mirror image
interface apb_intf;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic        pready;
  logic        pslverr;

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output prdata, pready, pslverr
  );

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/cfgreg_rstseq.sv
// Per-core reset-release sequencer: OFF -> HOLD (RST_DLY cycles) -> ON.
// Dropping req from HOLD or ON returns to OFF.
//   clk, rst : clock, synchronous active-high reset
//   req      : software release request for this core
//   rstn_o   : registered core reset, 0 = core held in reset
module cfgreg_rstseq
  import cfgreg_mc_pkg::*;
#(
  parameter int unsigned RST_DLY = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic rstn_o
);

  localparam int unsigned CW = cnt_width(RST_DLY);
  localparam logic [CW-1:0] CNT_LOAD = CW'((RST_DLY == 0) ? 32'd0 : RST_DLY - 1);

  rstseq_state_e state;
  logic [CW-1:0] cnt;

  // Counter is only decremented while non-zero, so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      cnt    <= '0;
      rstn_o <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (req) begin
            if (RST_DLY == 0) begin
              state  <= ON;
              rstn_o <= 1'b1;
            end else begin
              state <= HOLD;
              cnt   <= CNT_LOAD;
            end
          end
        end
        HOLD: begin
          if (!req) begin
            state <= OFF;
          end else if (cnt == '0) begin
            state  <= ON;
            rstn_o <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ON: begin
          if (!req) begin
            state  <= OFF;
            rstn_o <= 1'b0;
          end
        end
        default: begin
          state  <= OFF;
          rstn_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cfgreg_mc.sv
// Multi-core configuration register block on zero-wait-state APB.
// Holds per-core boot vectors, the DDR offset, scratch registers and the
// per-core reset release requests feeding one cfgreg_rstseq per core.
// Optional macro CFGREG_MC_LOCK_EN adds a sticky LOCK register at 0x00C
// that blocks DDROFFSET/BOOTVEC writes until rst.
//   clk, rst     : clock, synchronous active-high reset
//   apb          : APB slave (prdata/pslverr registered in setup phase)
//   core_bootvec : per-core boot vector
//   ddr_offset   : DDR address offset
//   core_rstn    : per-core reset, 0 = held in reset
module cfgreg_mc
  import cfgreg_mc_pkg::*;
#(
  parameter int unsigned NCORE          = 2,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NSCRATCH       = 2,
  parameter int unsigned RST_DLY        = 16,
  parameter logic [31:0] DDR_OFFSET_RST = 32'h2000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  apb_intf.slave                       apb,
  output logic [NCORE-1:0][XLEN-1:0]   core_bootvec,
  output logic [31:0]                  ddr_offset,
  output logic [NCORE-1:0]             core_rstn
);

  logic [ADDR_W-1:0]         addr;
  logic                      setup;
  logic                      wr;
  logic [NCORE-1:0]          req;
  logic [APB_DW-1:0]         scratch [NSCRATCH];
  logic [4:0]                bv_idx;
  logic [5:0]                scr_idx;
  logic                      bv_hit;
  logic                      scr_hit;
  logic                      locked;

  logic [APB_DW-1:0]         rdata_c;
  logic                      err_c;
  logic                      we_req_c;
  logic                      we_ddr_c;
  logic                      we_scr_c;
  logic                      we_lock_c;
  logic [NCORE-1:0][XLEN-1:0] bv_next_c;
  logic [63:0]               bv_ext;

  assign addr    = apb.paddr[ADDR_W-1:0];
  assign setup   = apb.psel & ~apb.penable;
  assign wr      = setup & apb.pwrite;
  assign bv_idx  = addr[7:3];
  assign scr_idx = addr[7:2];

  assign bv_hit  = (addr[11:8] == BOOTVEC_BASE[11:8]) && (addr[1:0] == 2'b00) &&
                   (32'(bv_idx) < NCORE);
  assign scr_hit = (addr[11:8] == SCRATCH_BASE[11:8]) && (addr[1:0] == 2'b00) &&
                   (32'(scr_idx) < NSCRATCH);

  assign apb.pready = 1'b1;

`ifdef CFGREG_MC_LOCK_EN
  logic lock;

  // Write-1-set, sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (we_lock_c && apb.pwdata[0]) begin
      lock <= 1'b1;
    end
  end

  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  // Address decode: read mux, write enables, error and next boot vectors
  always_comb begin
    rdata_c   = '0;
    err_c     = 1'b0;
    we_req_c  = 1'b0;
    we_ddr_c  = 1'b0;
    we_scr_c  = 1'b0;
    we_lock_c = 1'b0;
    bv_next_c = core_bootvec;
    bv_ext    = '0;

    if (addr == RSTREQ) begin
      rdata_c  = 32'(req);
      we_req_c = wr;
    end else if (addr == RSTSTAT) begin
      rdata_c = 32'(core_rstn);
      err_c   = wr;
    end else if (addr == DDROFFSET) begin
      rdata_c  = ddr_offset;
      err_c    = wr & locked;
      we_ddr_c = wr & ~locked;
`ifdef CFGREG_MC_LOCK_EN
    end else if (addr == LOCK) begin
      rdata_c   = 32'(lock);
      we_lock_c = wr;
`endif
    end else if (bv_hit) begin
      for (int i = 0; i < NCORE; i++) begin
        if (bv_idx == 5'(i)) begin
          bv_ext  = 64'(core_bootvec[i]);
          // The high word only exists for 64-bit boot vectors
          rdata_c = addr[2] ? ((XLEN == 64) ? bv_ext[63:32] : 32'd0) : bv_ext[31:0];
          if (wr && locked) begin
            err_c = 1'b1;
          end else if (wr) begin
            if (!addr[2]) begin
              bv_ext[31:0] = apb.pwdata;
            end else if (XLEN == 64) begin
              bv_ext[63:32] = apb.pwdata;
            end
            bv_next_c[i] = XLEN'(bv_ext);
          end
        end
      end
    end else if (scr_hit) begin
      for (int j = 0; j < NSCRATCH; j++) begin
        if (scr_idx == 6'(j)) begin
          rdata_c = scratch[j];
        end
      end
      we_scr_c = wr;
    end else begin
      err_c = wr;
    end
  end

  // Register state and APB response, captured on the edge ending setup
  always_ff @(posedge clk) begin
    if (rst) begin
      req          <= '0;
      ddr_offset   <= DDR_OFFSET_RST;
      core_bootvec <= '0;
      for (int j = 0; j < NSCRATCH; j++) begin
        scratch[j] <= '0;
      end
      apb.prdata   <= '0;
      apb.pslverr  <= 1'b0;
    end else begin
      if (setup) begin
        apb.prdata  <= rdata_c;
        apb.pslverr <= err_c;
      end
      if (we_req_c) begin
        req <= apb.pwdata[NCORE-1:0];
      end
      if (we_ddr_c) begin
        ddr_offset <= apb.pwdata;
      end
      core_bootvec <= bv_next_c;
      for (int j = 0; j < NSCRATCH; j++) begin
        if (we_scr_c && (scr_idx == 6'(j))) begin
          scratch[j] <= apb.pwdata;
        end
      end
    end
  end

  for (genvar i = 0; i < NCORE; i++) begin : g_seq
    cfgreg_rstseq #(
      .RST_DLY (RST_DLY)
    ) u_seq (
      .clk    (clk),
      .rst    (rst),
      .req    (req[i]),
      .rstn_o (core_rstn[i])
    );
  end

endmodule
